// File: rtl/simon_pkg.sv
// simon_pkg: constants shared by the Simon front end (FSM encoding, default debounce length).
package simon_pkg;
    localparam int DEBOUNCE_DEFAULT = 100000;
    localparam logic [2:0] ST_ARM        = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_DB_PRESS   = 3'd2;
    localparam logic [2:0] ST_HELD       = 3'd3;
    localparam logic [2:0] ST_DB_RELEASE = 3'd4;
endpackage

// File: rtl/sync2.sv
// sync2: parameterized-width two-flop synchronizer, cleared by reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    always_ff @(posedge clk) begin
        r_s1 <= rst ? '0 : i_d;
        r_s2 <= rst ? '0 : r_s1;
    end
    assign o_q = r_s2;
endmodule

// File: rtl/simon_input_conditioner.sv
// simon_input_conditioner: debounces the step button into a one-cycle pulse and
// captures the synchronized pattern/level switches on that pulse.
module simon_input_conditioner
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CTR_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [3:0] sw_raw,
    input  logic       level_raw,
    output logic       step,
    output logic [3:0] pattern,
    output logic       level,
    output logic       busy
);
    logic             w_btn_s;
    logic [4:0]       w_sw_lvl_s;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nx;
    logic [CTR_W-1:0] r_cnt;
    logic [CTR_W-1:0] w_cnt_nx;
    logic [CTR_W-1:0] w_cnt_inc;
    logic             w_term;
    logic             w_fire;
    logic             r_step;
    logic [3:0]       r_pattern;
    logic             r_level;

    sync2 #(.W(1)) u_sync_btn (.clk(clk), .rst(rst), .i_d(btn_raw), .o_q(w_btn_s));
    sync2 #(.W(5)) u_sync_sw  (.clk(clk), .rst(rst), .i_d({level_raw, sw_raw}), .o_q(w_sw_lvl_s));

    assign w_term    = r_cnt == CTR_W'(DEBOUNCE_CYCLES - 1);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_fire    = (r_state == ST_DB_PRESS) && w_btn_s && w_term;

    // Every terminal count or level change clears cnt, so it never wraps.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = '0;
        case (r_state)
            ST_ARM: begin
                w_state_nx = (!w_btn_s && w_term) ? ST_IDLE : ST_ARM;
                w_cnt_nx   = (w_btn_s || w_term) ? '0 : w_cnt_inc;
            end
            ST_IDLE:       w_state_nx = w_btn_s ? ST_DB_PRESS : ST_IDLE;
            ST_DB_PRESS: begin
                w_state_nx = !w_btn_s ? ST_IDLE : (w_term ? ST_HELD : ST_DB_PRESS);
                w_cnt_nx   = (!w_btn_s || w_term) ? '0 : w_cnt_inc;
            end
            ST_HELD:       w_state_nx = w_btn_s ? ST_HELD : ST_DB_RELEASE;
            ST_DB_RELEASE: begin
                w_state_nx = w_btn_s ? ST_HELD : (w_term ? ST_IDLE : ST_DB_RELEASE);
                w_cnt_nx   = (w_btn_s || w_term) ? '0 : w_cnt_inc;
            end
            default:       w_state_nx = ST_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ARM;
            r_cnt     <= '0;
            r_step    <= 1'b0;
            r_pattern <= 4'b0000;
            r_level   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_step    <= w_fire;
            r_pattern <= w_fire ? w_sw_lvl_s[3:0] : r_pattern;
            r_level   <= w_fire ? w_sw_lvl_s[4] : r_level;
        end
    end

    assign step    = r_step;
    assign pattern = r_pattern;
    assign level   = r_level;
    assign busy    = r_state != ST_IDLE;
endmodule

// File: tb/tb_simon_input_conditioner.sv
// tb_simon_input_conditioner: directed scenarios plus random button/switch traffic,
// scored against a run-length model of the debounce rules.
module tb_simon_input_conditioner;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic [3:0] sw_raw = 4'b0000;
    logic       level_raw = 1'b0;
    logic       step;
    logic [3:0] pattern;
    logic       level;
    logic       busy;

    int checks = 0;
    int errors = 0;

    simon_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw), .level_raw(level_raw),
        .step(step), .pattern(pattern), .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] pat;
        logic       lvl;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         mode = 0;
    int         run = 0;
    int         nsteps = 0;
    logic [5:0] p0 = '0;
    logic [5:0] p1 = '0;
    logic [3:0] ep = '0;
    logic       el = 1'b0;
    logic       mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: mode 0 waits for D low samples after reset, mode 1 is ready and
    // fires after D+1 consecutive high samples, mode 2 waits for D+1 low samples.
    // p1 holds {btn,lvl,sw} as the DUT sees them after two sampling edges.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mode = 0;
            run = 0;
            p0 = '0;
            p1 = '0;
            ep = '0;
            el = 1'b0;
        end else begin
            case (mode)
                0: begin
                    run = p1[5] ? 0 : run + 1;
                    if (run == D) begin mode = 1; run = 0; end
                end
                1: begin
                    run = p1[5] ? run + 1 : 0;
                    if (run == D + 1) begin
                        mode = 2;
                        run = 0;
                        ep = p1[3:0];
                        el = p1[4];
                        q.push_back('{cyc, p1[3:0], p1[4]});
                    end
                end
                default: begin
                    run = p1[5] ? 0 : run + 1;
                    if (run == D + 1) begin mode = 1; run = 0; end
                end
            endcase
            p1 = p0;
            p0 = {btn_raw, level_raw, sw_raw};
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL step_missed cyc=%0d got=none expected_at=%0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (step) begin
                nsteps++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL step_unexpected cyc=%0d got=1 expected=0", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("step_cycle", cyc, e.cyc);
                    chk("step_pattern", int'(pattern), int'(e.pat));
                    chk("step_level", int'(level), int'(e.lvl));
                end
            end
            chk("busy", int'(busy), int'(!(mode == 1 && run == 0)));
            chk("pattern_hold", int'(pattern), int'(ep));
            chk("level_hold", int'(level), int'(el));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_steps(input string name, input int n0, input int exp);
        chk(name, nsteps - n0, exp);
    endtask

    task automatic press(input int hi, input int lo);
        btn_raw = 1'b1;
        tick(hi);
        btn_raw = 1'b0;
        tick(lo);
    endtask

    initial begin
        int n0;
        tick(2);
        mon_en = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("reset_step", int'(step), 0);
        chk("reset_pattern", int'(pattern), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_busy", int'(busy), 1);

        // clean press
        tick(10);
        n0 = nsteps;
        sw_raw = 4'b0100;
        level_raw = 1'b1;
        press(20, 12);
        expect_steps("clean_press_count", n0, 1);
        chk("clean_press_pattern", int'(pattern), 4'b0100);
        chk("clean_press_level", int'(level), 1);

        // bounce on press
        n0 = nsteps;
        sw_raw = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            btn_raw = ~i[0];
            tick(1);
        end
        press(20, 12);
        expect_steps("bounce_press_count", n0, 1);

        // long hold then bouncy release
        n0 = nsteps;
        sw_raw = 4'b1000;
        btn_raw = 1'b1;
        tick(50);
        for (int i = 0; i < 2; i++) begin
            btn_raw = 1'b0;
            tick(2);
            btn_raw = 1'b1;
            tick(1);
        end
        btn_raw = 1'b0;
        tick(12);
        expect_steps("long_hold_count", n0, 1);

        // button held through reset
        n0 = nsteps;
        btn_raw = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("held_reset_busy", int'(busy), 1);
        expect_steps("held_reset_none", n0, 0);
        btn_raw = 1'b0;
        tick(10);
        sw_raw = 4'b0001;
        press(12, 12);
        expect_steps("held_reset_after", n0, 1);

        // switch isolation
        chk("iso_pattern_before", int'(pattern), 4'b0001);
        sw_raw = 4'b1000;
        tick(10);
        chk("iso_pattern_idle", int'(pattern), 4'b0001);
        press(12, 12);
        chk("iso_pattern_after", int'(pattern), 4'b1000);

        // reset while DB_PRESS has counted to 2
        n0 = nsteps;
        btn_raw = 1'b1;
        tick(5);
        rst = 1'b1;
        btn_raw = 1'b0;
        tick(1);
        chk("midreset_step", int'(step), 0);
        chk("midreset_pattern", int'(pattern), 0);
        chk("midreset_level", int'(level), 0);
        chk("midreset_busy", int'(busy), 1);
        rst = 1'b0;
        tick(12);
        expect_steps("midreset_none", n0, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int len;
            btn_raw = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                sw_raw = 4'($urandom);
                level_raw = 1'($urandom);
                rst = ($urandom_range(0, 199) == 0);
                tick(1);
            end
            rst = 1'b0;
        end
        btn_raw = 1'b0;
        tick(20);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
